fib_sequencer: RTL and testbench
================================

Name: fib_sequencer

Overview:
- Controller for the 16-bit Fibonacci generator (ports f_en / f_valid / f_out, async reset).
- Accepts a job request for N terms, clears the generator, and drives its enable to produce exactly N distinct terms.
- Drops the repeated value the generator emits after a pause, buffers terms in a small FIFO, and streams them out with valid/ready backpressure.

Parameters:
- DEPTH, 4, output FIFO depth in entries (power of two, 2..16).
- CNT_W, 8, width of the requested term count.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  job request
- req_count  in  CNT_W  number of terms requested
- req_ready  out  1  high only in IDLE
- fib_rst  out  1  registered reset pulse to the generator's reset input
- fib_en  out  1  generator enable, drives f_en
- fib_valid  in  1  from generator f_valid
- fib_out  in  16  from generator f_out
- out_valid  out  1  term available
- out_data  out  16  term value
- out_last  out  1  marks the final term of the job
- out_ready  in  1  consumer accepts the term
- done  out  1  one-cycle pulse at job completion
- trunc  out  1  job count was saturated; valid with done

Behaviour:
- Reset: state IDLE; FIFO empty; all counters 0.
  - Outputs: fib_rst=1 (holds the generator cleared), fib_en=0, out_valid=0, done=0, trunc=0, req_ready=0 during reset, then 1.
- States: IDLE, CLEAR, RUN, DRAIN.
- IDLE:
  - req_valid & req_ready: latch target = min(req_count, MAX_TERMS=24) and trunc_r = (req_count > 24).
  - Go to CLEAR.
- CLEAR (1 cycle):
  - fib_rst=1, fib_en=0, hold mirror cleared to 0, issue counter cleared.
  - If target==0, go to DRAIN; otherwise go to RUN.
- Hold mirror: each cycle hold_m <= ~fib_en. This exactly tracks the generator's internal hold bit.
- Advance: a cycle with fib_en=1 and hold_m=0. The generator's result updates at the end of that cycle.
- RUN:
  - fib_en = (issued < target) & (fifo_count + inflight < DEPTH). inflight = advance registered from the previous cycle (0 or 1).
  - issued increments on every advance.
  - Go to DRAIN when issued==target and no advance is in flight.
- Capture:
  - Push fib_out into the FIFO in cycle t+1 iff cycle t was an advance. fib_valid must also be 1; assert it in simulation.
  - A cycle with fib_en=1 and hold_m=1 (resume after a pause) is never captured. This guarantees no duplicates.
- Output stream:
  - out_valid = FIFO non-empty; out_data = FIFO head; pop on out_valid & out_ready.
  - out_last=1 when the head is term number target. Track this with an output counter compared against target.
  - out_data/out_last hold stable while out_valid & ~out_ready.
- DRAIN:
  - fib_en=0. When the FIFO is empty and the last term has been popped (or target==0), pulse done=1 and drive trunc=trunc_r in the same cycle.
  - Return to IDLE.
- Latency, with the handshake in cycle 0:
  - fib_rst cycle 1.
  - fib_en cycle 2.
  - First push end of cycle 3.
  - out_valid cycle 4.
  - With out_ready held at 1: one term per cycle, no bubbles.
- Width rule: 24 is the largest term index whose value fits in 16 bits (F24=46368, F25=75025 overflows). Counts above 24 are saturated to 24 and trunc is set.
- fib_rst stays low outside CLEAR and reset, and comes directly from a flop.
- req_valid outside IDLE is ignored; req_ready=0.
- Push and pop in the same cycle on a full FIFO is legal: count is unchanged, no data is lost.
- Async reset mid-job aborts immediately. All state returns to reset values, the FIFO is flushed, and no done pulse is issued.

Decomposition:
- Shared package/header fib_pkg: state encoding (IDLE, CLEAR, RUN, DRAIN), MAX_TERMS=24, FIB_W=16.
- Sub-module fib_fifo: synchronous FIFO, DEPTH × 16, push/pop/full/empty/count, async active-high reset.
- The FSM, counters and hold mirror stay in fib_sequencer.

Test Plan:
- count=5, out_ready=1 → fib_rst in cycle 1; outputs 1,1,2,3,5 in cycles 4..8; out_last on 5; done in cycle 9; trunc=0.
- count=10, out_ready low for cycles 4..15 → fib_en drops once DEPTH=4 is reached; after release, exactly 1,1,2,3,5,8,13,21,34,55 with no duplicates; FIFO never overflows.
- count=30 → 24 terms; last term 46368 with out_last; done with trunc=1.
- count=0 → CLEAR then DRAIN; no out_valid; done pulse with trunc=0; req_ready back to 1 the next cycle.
- Random out_ready (50%), count=24, back-to-back jobs → each job restarts at 1; scoreboard matches the reference Fibonacci sequence; second request is accepted only in IDLE.
- Reset asserted mid-RUN after 3 terms → outputs at reset values, FIFO empty; new job count=3 yields 1,1,2.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequencer: state encoding and term limits.
package fib_pkg;

    // Width of one Fibonacci term as produced by the generator
    localparam int FIB_W = 16;

    // Largest term index whose value still fits in FIB_W bits (F24 = 46368)
    localparam int MAX_TERMS = 24;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/fib_fifo.sv
// Small synchronous FIFO that buffers Fibonacci terms between generator and consumer.
module fib_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage is written only on accepted pushes; reads are gated by count so no reset is needed
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fib_sequencer.sv
// Job controller for the 16-bit Fibonacci generator: clears it, enables it for exactly N
// fresh terms, discards the repeat it emits after a pause, and streams terms out with backpressure.
module fib_sequencer
    import fib_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [CNT_W-1:0] req_count,
    output logic             req_ready,
    output logic             fib_rst,
    output logic             fib_en,
    input  logic             fib_valid,
    input  logic [FIB_W-1:0] fib_out,
    output logic             out_valid,
    output logic [FIB_W-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             done,
    output logic             trunc
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] out_cnt;
    logic             trunc_r;
    logic             hold_m;
    logic             inflight;
    logic             fib_rst_q;

    logic             accept;
    logic             sat_over;
    logic [CNT_W-1:0] sat_count;
    logic             advance;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      occupancy;
    logic             room;
    logic [FIB_W-1:0] head;

    // Requests are only taken in IDLE and never while reset is held
    assign req_ready = (state == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // Counts beyond the 16-bit range are clipped and flagged
    assign sat_over  = (req_count > CNT_W'(MAX_TERMS));
    assign sat_count = sat_over ? CNT_W'(MAX_TERMS) : req_count;

    // Only an enable with the generator's hold bit clear produces a new term
    assign advance   = fib_en && !hold_m;
    assign push      = inflight && fib_valid;
    assign pop       = out_valid && out_ready;

    // Reserve a slot for the term that is still on its way from the generator
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign room      = (occupancy < (CW+1)'(DEPTH));

    assign out_valid = !fifo_empty;
    assign out_data  = head;
    assign out_last  = out_valid && ((out_cnt + CNT_W'(1)) == target);
    assign fib_rst   = fib_rst_q;

    fib_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIB_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (fib_out),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state logic plus generator enable and job completion outputs
    always_comb begin
        next_state = state;
        fib_en     = 1'b0;
        done       = 1'b0;
        trunc      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                next_state = (target == '0) ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                fib_en = (issued < target) && room;
                if ((issued == target) && !inflight) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && (out_cnt == target)) begin
                    done       = 1'b1;
                    trunc      = trunc_r;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register; the generator reset is a flop that is high exactly in CLEAR and during reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            fib_rst_q <= 1'b1;
        end else begin
            state     <= next_state;
            fib_rst_q <= (next_state == ST_CLEAR);
        end
    end

    // Job parameters, issue/output counters and the mirror of the generator's hold bit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            target   <= '0;
            trunc_r  <= 1'b0;
            issued   <= '0;
            out_cnt  <= '0;
            hold_m   <= 1'b0;
            inflight <= 1'b0;
        end else begin
            if (accept) begin
                target  <= sat_count;
                trunc_r <= sat_over;
            end
            if (state == ST_CLEAR) begin
                issued   <= '0;
                out_cnt  <= '0;
                hold_m   <= 1'b0;
                inflight <= 1'b0;
            end else begin
                hold_m   <= !fib_en;
                inflight <= advance;
                if (advance) begin
                    issued <= issued + CNT_W'(1);
                end
                if (pop) begin
                    out_cnt <= out_cnt + CNT_W'(1);
                end
            end
        end
    end

    // A captured term must come with the generator's valid flag
    capture_valid_a : assert property (@(posedge clock) disable iff (reset) inflight |-> fib_valid);

    // The enable throttle must keep pushes away from a full FIFO unless the head leaves
    no_overflow_a : assert property (@(posedge clock) disable iff (reset) push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_fib_sequencer.sv
// Self-checking bench for fib_sequencer with a behavioural model of the 16-bit Fibonacci generator.
module tb_fib_sequencer;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic [7:0]  req_count;
    logic        req_ready;
    logic        fib_rst;
    logic        fib_en;
    logic        fib_valid;
    logic [15:0] fib_out;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        done;
    logic        trunc;

    int errors = 0;
    int checks = 0;

    logic [15:0] fib_ref [24];

    typedef struct packed {
        logic        req_valid;
        logic [7:0]  req_count;
        logic        out_ready;
        logic        exp_req_ready;
        logic        exp_fib_rst;
        logic        exp_fib_en;
        logic        exp_out_valid;
        logic [15:0] exp_data;
        logic        exp_last;
        logic        exp_done;
        logic        exp_trunc;
    } vec_t;

    typedef struct packed {
        logic [7:0] count;
        logic [7:0] exp_terms;
        logic       exp_trunc;
        logic [1:0] mode;
    } job_t;

    vec_t vecs [11];
    job_t jobs [9];

    fib_sequencer #(
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_count (req_count),
        .req_ready (req_ready),
        .fib_rst   (fib_rst),
        .fib_en    (fib_en),
        .fib_valid (fib_valid),
        .fib_out   (fib_out),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .done      (done),
        .trunc     (trunc)
    );

    // Clock generation
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Generator model: advances when enabled with hold clear, re-emits its last value on resume
    logic [15:0] g_nxt;
    logic        g_hold;
    always_ff @(posedge clock or posedge fib_rst) begin
        if (fib_rst) begin
            fib_out   <= 16'd0;
            g_nxt     <= 16'd1;
            g_hold    <= 1'b0;
            fib_valid <= 1'b0;
        end else begin
            g_hold    <= ~fib_en;
            fib_valid <= fib_en;
            if (fib_en && !g_hold) begin
                fib_out <= g_nxt;
                g_nxt   <= fib_out + g_nxt;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic rv, input logic [7:0] rc, input logic ordy,
                                input logic rr, input logic rst, input logic en, input logic ov,
                                input logic [15:0] d, input logic l, input logic dn, input logic tr);
        vec_t v;
        v.req_valid     = rv;
        v.req_count     = rc;
        v.out_ready     = ordy;
        v.exp_req_ready = rr;
        v.exp_fib_rst   = rst;
        v.exp_fib_en    = en;
        v.exp_out_valid = ov;
        v.exp_data      = d;
        v.exp_last      = l;
        v.exp_done      = dn;
        v.exp_trunc     = tr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req_valid = v.req_valid;
        req_count = v.req_count;
        out_ready = v.out_ready;
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, " req_ready"}, req_ready, 0);
        checkOutput({tag, " fib_rst"},   fib_rst,   1);
        checkOutput({tag, " fib_en"},    fib_en,    0);
        checkOutput({tag, " out_valid"}, out_valid, 0);
        checkOutput({tag, " done"},      done,      0);
        checkOutput({tag, " trunc"},     trunc,     0);
    endtask

    // One job: handshake in cycle 0, then consume terms according to the ready mode
    // mode 0: always ready, mode 1: ready low in cycles 4..15, mode 2: random ready
    task automatic run_job(input string name, input int count, input int exp_terms,
                           input logic exp_trunc, input int mode, input int abort_after);
        int          got;
        bit          finished;
        bit          prev_stall;
        logic [15:0] prev_data;
        logic        prev_last;
        got        = 0;
        finished   = 0;
        prev_stall = 0;
        prev_data  = '0;
        prev_last  = 1'b0;
        @(posedge clock);
        #1;
        req_valid = 1'b1;
        req_count = 8'(count);
        out_ready = 1'b1;
        #1;
        checkOutput({name, " req_ready"}, req_ready, 1);
        for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
            @(posedge clock);
            #1;
            req_valid = 1'b1;
            req_count = 8'd3;
            case (mode)
                1:       out_ready = !(cyc >= 4 && cyc <= 15);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            #1;
            checkOutput({name, " busy req_ready"}, req_ready, 0);
            if (prev_stall) begin
                checkOutput({name, " held valid"}, out_valid, 1);
                checkOutput({name, " held data"},  out_data,  prev_data);
                checkOutput({name, " held last"},  out_last,  prev_last);
            end
            if (mode == 1 && cyc == 10) begin
                checkOutput({name, " stalled fib_en"}, fib_en, 0);
            end
            if (out_valid && out_ready) begin
                if (got < 24) begin
                    checkOutput({name, " term"}, out_data, fib_ref[got]);
                end else begin
                    checkOutput({name, " extra term"}, got, 24);
                end
                checkOutput({name, " out_last"}, out_last, (got == exp_terms - 1));
                got++;
                if (abort_after != 0 && got == abort_after) begin
                    finished = 1;
                end
            end
            if (done && !finished) begin
                finished = 1;
                checkOutput({name, " trunc"},      trunc, exp_trunc);
                checkOutput({name, " term count"}, got,   exp_terms);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
        if (!finished) begin
            checkOutput({name, " done timeout"}, 0, 1);
        end
        req_valid = 1'b0;
    endtask

    initial begin
        fib_ref = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34, 16'd55,
                    16'd89, 16'd144, 16'd233, 16'd377, 16'd610, 16'd987, 16'd1597, 16'd2584,
                    16'd4181, 16'd6765, 16'd10946, 16'd17711, 16'd28657, 16'd46368};

        // count=5 with out_ready high, cycle by cycle from the handshake
        vecs[0]  = mk(1, 8'd5, 1,  1, 0, 0, 0, 16'd0, 0, 0, 0);
        vecs[1]  = mk(0, 8'd0, 1,  0, 1, 0, 0, 16'd0, 0, 0, 0);
        vecs[2]  = mk(0, 8'd0, 1,  0, 0, 1, 0, 16'd0, 0, 0, 0);
        vecs[3]  = mk(0, 8'd0, 1,  0, 0, 1, 0, 16'd0, 0, 0, 0);
        vecs[4]  = mk(0, 8'd0, 1,  0, 0, 1, 1, 16'd1, 0, 0, 0);
        vecs[5]  = mk(0, 8'd0, 1,  0, 0, 1, 1, 16'd1, 0, 0, 0);
        vecs[6]  = mk(0, 8'd0, 1,  0, 0, 1, 1, 16'd2, 0, 0, 0);
        vecs[7]  = mk(0, 8'd0, 1,  0, 0, 0, 1, 16'd3, 0, 0, 0);
        vecs[8]  = mk(0, 8'd0, 1,  0, 0, 0, 1, 16'd5, 1, 0, 0);
        vecs[9]  = mk(0, 8'd0, 1,  0, 0, 0, 0, 16'd0, 0, 1, 0);
        vecs[10] = mk(0, 8'd0, 1,  1, 0, 0, 0, 16'd0, 0, 0, 0);

        // Back-to-back jobs: {count, expected terms, expected trunc, ready mode}
        jobs[0] = '{8'd10,  8'd10, 1'b0, 2'd1};
        jobs[1] = '{8'd30,  8'd24, 1'b1, 2'd0};
        jobs[2] = '{8'd0,   8'd0,  1'b0, 2'd0};
        jobs[3] = '{8'd1,   8'd1,  1'b0, 2'd0};
        jobs[4] = '{8'd24,  8'd24, 1'b0, 2'd2};
        jobs[5] = '{8'd24,  8'd24, 1'b0, 2'd2};
        jobs[6] = '{8'd255, 8'd24, 1'b1, 2'd2};
        jobs[7] = '{8'd25,  8'd24, 1'b1, 2'd0};
        jobs[8] = '{8'd2,   8'd2,  1'b0, 2'd2};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_count = 8'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        check_reset_outputs("reset");
        #1;
        reset = 1'b0;
        @(posedge clock);
        #2;
        checkOutput("post-reset req_ready", req_ready, 1);
        checkOutput("post-reset fib_rst",   fib_rst,   0);

        for (int i = 0; i < 11; i++) begin
            @(posedge clock);
            #1;
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d req_ready", i), req_ready, vecs[i].exp_req_ready);
            checkOutput($sformatf("vec%0d fib_rst", i),   fib_rst,   vecs[i].exp_fib_rst);
            checkOutput($sformatf("vec%0d fib_en", i),    fib_en,    vecs[i].exp_fib_en);
            checkOutput($sformatf("vec%0d out_valid", i), out_valid, vecs[i].exp_out_valid);
            if (vecs[i].exp_out_valid) begin
                checkOutput($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
            end
            checkOutput($sformatf("vec%0d out_last", i),  out_last,  vecs[i].exp_last);
            checkOutput($sformatf("vec%0d done", i),      done,      vecs[i].exp_done);
            checkOutput($sformatf("vec%0d trunc", i),     trunc,     vecs[i].exp_trunc);
        end

        for (int j = 0; j < 9; j++) begin
            run_job($sformatf("job%0d", j), int'(jobs[j].count), int'(jobs[j].exp_terms),
                    jobs[j].exp_trunc, int'(jobs[j].mode), 0);
        end

        // Abort mid-RUN after three terms with an asynchronous reset
        run_job("abort", 10, 10, 1'b0, 0, 3);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid-job reset");
        repeat (2) @(posedge clock);
        #2;
        checkOutput("reset hold done", done, 0);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #2;
        checkOutput("after abort out_valid", out_valid, 0);
        checkOutput("after abort req_ready", req_ready, 1);
        run_job("restart", 3, 3, 1'b0, 0, 0);

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
